rc4_stream_decrypt: RTL and testbench

Ciphertext-to-plaintext stage of the RC4 link. It buffers keystream bytes from the RC4 keystream generator in a small FIFO and XORs them one-for-one with framed ciphertext bytes. Ciphertext arrives on a valid/ready stream; plaintext leaves on a registered valid/ready stream. It is the receive-side counterpart of the byte encryptor and sits between the link receiver and the consumer.

---
 rtl/rc4_pkg.sv | 13 +
 rtl/rc4_ks_fifo.sv | 65 ++++++
 rtl/rc4_stream_decrypt.sv | 145 ++++++++++++++
 tb/tb_rc4_stream_decrypt.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 receive path.
// State encoding for the decrypt FSM plus the byte width.
package rc4_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    WAIT_INIT,
    RUN,
    DRAIN
  } state_t;

endpackage

// File: rtl/rc4_ks_fifo.sv
// Keystream FIFO: power-of-two depth, sticky drop flag on push-at-full.
// Pointers wrap naturally in their AW-bit registers.
module rc4_ks_fifo
  import rc4_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic [BYTE_W-1:0]       i_data,
  output logic [BYTE_W-1:0]       o_data,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_full,
  output logic                    o_empty,
  output logic                    o_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_C  = (AW+1)'(1);
  localparam logic [AW-1:0] PONE_C = AW'(1);

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wp;
  logic [AW-1:0]     r_rp;
  logic [AW:0]       r_cnt;
  logic              r_drop;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_full    = (r_cnt == FULL_C);
  assign o_empty   = (r_cnt == '0);
  assign w_do_pop  = i_pop && !o_empty;
  // At full a push is only accepted when a pop frees the slot this edge.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_drop <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wp] <= i_data;
        r_wp        <= r_wp + PONE_C;
      end
      if (w_do_pop) r_rp <= r_rp + PONE_C;
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + ONE_C;
        2'b01:   r_cnt <= r_cnt - ONE_C;
        default: r_cnt <= r_cnt;
      endcase
      if (i_push && !w_do_push) r_drop <= 1'b1;
    end
  end

  assign o_data  = r_mem[r_rp];
  assign o_count = r_cnt;
  assign o_drop  = r_drop;

endmodule

// File: rtl/rc4_stream_decrypt.sv
// RC4 ciphertext-to-plaintext stage: keystream FIFO, XOR, registered output.
// Optional per-message checksum built when RC4_DEC_CHECKSUM_EN is defined.
module rc4_stream_decrypt
  import rc4_pkg::*;
#(
  parameter int KS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_done,
  input  logic              ks_valid,
  input  logic [BYTE_W-1:0] ks_data,
  output logic              ks_stall,
  input  logic              ct_valid,
  output logic              ct_ready,
  input  logic [BYTE_W-1:0] ct_data,
  input  logic              ct_last,
  output logic              pt_valid,
  input  logic              pt_ready,
  output logic [BYTE_W-1:0] pt_data,
  output logic              pt_last,
  output logic              msg_done,
  output logic              ks_overflow,
  output logic              chk_valid,
  output logic              chk_ok
);

  localparam int AW = $clog2(KS_DEPTH);
  localparam logic [AW:0] STALL_AT = (AW+1)'(KS_DEPTH - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_pt_valid;
  logic [BYTE_W-1:0] r_pt_data;
  logic              r_pt_last;
  logic              r_msg_done;
  logic              r_stall;
  logic              w_ct_ready;
  logic              w_ct_hs;
  logic              w_pt_hs;
  logic              w_msg_end;
  logic              w_active;
  logic [BYTE_W-1:0] w_head;
  logic [BYTE_W-1:0] w_pt_byte;
  logic [AW:0]       w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_drop;

  assign w_active  = (r_state != WAIT_INIT);
  assign w_pt_hs   = r_pt_valid && pt_ready;
  assign w_ct_hs   = ct_valid && w_ct_ready;
  assign w_pt_byte = ct_data ^ w_head;
  assign w_msg_end = (r_state == DRAIN) && w_pt_hs && r_pt_last;

  rc4_ks_fifo #(
    .DEPTH (KS_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_active && ks_valid),
    .i_pop   (w_ct_hs),
    .i_data  (ks_data),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_drop  (w_drop)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_ct_ready  = 1'b0;
    unique case (r_state)
      WAIT_INIT: begin
        if (init_done) w_state_nxt = RUN;
      end
      RUN: begin
        w_ct_ready = !w_empty && (!r_pt_valid || pt_ready);
        if (ct_valid && w_ct_ready && ct_last) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_pt_hs && r_pt_last) w_state_nxt = RUN;
      end
      default: w_state_nxt = WAIT_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= WAIT_INIT;
      r_pt_valid <= 1'b0;
      r_pt_data  <= '0;
      r_pt_last  <= 1'b0;
      r_msg_done <= 1'b0;
      r_stall    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_msg_done <= w_msg_end;
      r_stall    <= w_full || (w_count >= STALL_AT);
      if (w_ct_hs) begin
        r_pt_valid <= 1'b1;
        r_pt_data  <= w_pt_byte;
        r_pt_last  <= ct_last;
      end else if (w_pt_hs) begin
        r_pt_valid <= 1'b0;
      end
    end
  end

`ifdef RC4_DEC_CHECKSUM_EN
  logic [BYTE_W-1:0] r_sum;
  logic              r_chk_valid;
  logic              r_chk_ok;

  // The last byte is the checksum itself, so it never enters the sum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sum       <= '0;
      r_chk_valid <= 1'b0;
      r_chk_ok    <= 1'b0;
    end else begin
      r_chk_valid <= w_msg_end;
      r_chk_ok    <= w_msg_end && (r_sum == r_pt_data);
      if (w_msg_end) r_sum <= '0;
      else if (w_ct_hs && !ct_last) r_sum <= r_sum ^ w_pt_byte;
    end
  end

  assign chk_valid = r_chk_valid;
  assign chk_ok    = r_chk_ok;
`else
  assign chk_valid = 1'b0;
  assign chk_ok    = 1'b0;
`endif

  assign ct_ready    = w_ct_ready;
  assign pt_valid    = r_pt_valid;
  assign pt_data     = r_pt_data;
  assign pt_last     = r_pt_last;
  assign msg_done    = r_msg_done;
  assign ks_stall    = r_stall;
  assign ks_overflow = w_drop;

endmodule

// File: tb/tb_rc4_stream_decrypt.sv
// Bench for rc4_stream_decrypt: directed steps plus random traffic
// against a queue-based model of the keystream and message rules.
module tb_rc4_stream_decrypt;

  localparam int KS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       init_done = 1'b0;
  logic       ks_valid = 1'b0;
  logic [7:0] ks_data = '0;
  logic       ks_stall;
  logic       ct_valid = 1'b0;
  logic       ct_ready;
  logic [7:0] ct_data = '0;
  logic       ct_last = 1'b0;
  logic       pt_valid;
  logic       pt_ready = 1'b0;
  logic [7:0] pt_data;
  logic       pt_last;
  logic       msg_done;
  logic       ks_overflow;
  logic       chk_valid;
  logic       chk_ok;

  rc4_stream_decrypt #(.KS_DEPTH(KS)) dut (
    .clk         (clk),
    .rst         (rst),
    .init_done   (init_done),
    .ks_valid    (ks_valid),
    .ks_data     (ks_data),
    .ks_stall    (ks_stall),
    .ct_valid    (ct_valid),
    .ct_ready    (ct_ready),
    .ct_data     (ct_data),
    .ct_last     (ct_last),
    .pt_valid    (pt_valid),
    .pt_ready    (pt_ready),
    .pt_data     (pt_data),
    .pt_last     (pt_last),
    .msg_done    (msg_done),
    .ks_overflow (ks_overflow),
    .chk_valid   (chk_valid),
    .chk_ok      (chk_ok)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: phase 0 = waiting for init, 1 = accepting, 2 = draining last byte
  logic [7:0] mq[$];
  int         m_ph;
  logic       m_pv, m_pl, m_md, m_ovf, m_st, m_cv, m_ck;
  logic [7:0] m_pd, m_sum;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ph = 0; m_pv = 0; m_pl = 0; m_md = 0; m_ovf = 0;
    m_st = 0; m_cv = 0; m_ck = 0; m_pd = '0; m_sum = '0;
  endtask

  task automatic check_regs();
    chk("pt_valid", {7'd0, pt_valid}, {7'd0, m_pv});
    chk("pt_data", pt_data, m_pd);
    chk("pt_last", {7'd0, pt_last}, {7'd0, m_pl});
    chk("msg_done", {7'd0, msg_done}, {7'd0, m_md});
    chk("ks_overflow", {7'd0, ks_overflow}, {7'd0, m_ovf});
    chk("ks_stall", {7'd0, ks_stall}, {7'd0, m_st});
    chk("chk_valid", {7'd0, chk_valid}, {7'd0, m_cv});
    chk("chk_ok", {7'd0, chk_ok}, {7'd0, m_ck});
  endtask

  task automatic set_in(input logic kv, input logic [7:0] kd,
                        input logic cv, input logic [7:0] cd,
                        input logic cl, input logic pr);
    ks_valid = kv; ks_data = kd;
    ct_valid = cv; ct_data = cd; ct_last = cl;
    pt_ready = pr;
  endtask

  // One clock: check ct_ready, advance the model, check registered outputs.
  task automatic cyc();
    logic       rdy, cths, pths;
    int         sz0, nph;
    logic [7:0] pbyte;
    #1;
    rdy = (m_ph == 1) && (mq.size() > 0) && (!m_pv || pt_ready);
    chk("ct_ready", {7'd0, ct_ready}, {7'd0, rdy});
    cths = ct_valid && rdy;
    pths = m_pv && pt_ready;
    sz0  = mq.size();
    nph  = m_ph;
    m_st = (sz0 >= KS - 1);
    m_md = 0; m_cv = 0; m_ck = 0;
    if (m_ph == 0 && init_done) nph = 1;
    if (m_ph == 2 && pths && m_pl) begin
      m_md = 1;
`ifdef RC4_DEC_CHECKSUM_EN
      m_cv = 1;
      m_ck = (m_sum == m_pd);
`endif
      m_sum = '0;
      nph = 1;
    end
    if (cths) begin
      pbyte = ct_data ^ mq.pop_front();
      if (!ct_last) m_sum = m_sum ^ pbyte;
      if (ct_last) nph = 2;
      m_pv = 1; m_pd = pbyte; m_pl = ct_last;
    end else if (pths) begin
      m_pv = 0;
    end
    if (m_ph != 0 && ks_valid) begin
      if (sz0 < KS || cths) mq.push_back(ks_data);
      else m_ovf = 1;
    end
    m_ph = nph;
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_regs();
    chk("rst_ct_ready", {7'd0, ct_ready}, 8'd0);
    @(posedge clk);
    #1;
    check_regs();
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    check_regs();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // WAIT_INIT gating: ct and ks ignored
    set_in(1, 8'h77, 1, 8'h10, 0, 1);
    cyc();
    cyc();
    chk("wait_no_pt", {7'd0, pt_valid}, 8'd0);

    // leave WAIT_INIT, then init_done changes are ignored
    init_done = 1'b1;
    set_in(0, 8'h00, 0, 8'h00, 0, 1);
    cyc();
    init_done = 1'b0;

    // basic decrypt
    set_in(1, 8'hA5, 1, 8'h00, 0, 1);
    cyc();
    chk("empty_gate", {7'd0, pt_valid}, 8'd0);
    set_in(1, 8'h3C, 1, 8'h00, 0, 1);
    cyc();
    chk("basic_pt0", pt_data, 8'hA5);
    set_in(0, 8'h00, 1, 8'hFF, 1, 1);
    cyc();
    chk("basic_pt1", pt_data, 8'hC3);
    chk("basic_last", {7'd0, pt_last}, 8'd1);
    set_in(0, 8'h00, 0, 8'h00, 0, 1);
    cyc();
    chk("basic_done", {7'd0, msg_done}, 8'd1);
    cyc();
    chk("done_pulse", {7'd0, msg_done}, 8'd0);

    // backpressure
    set_in(1, 8'h11, 0, 8'h00, 0, 1);
    cyc();
    set_in(1, 8'h22, 0, 8'h00, 0, 1);
    cyc();
    set_in(0, 8'h00, 1, 8'h40, 0, 1);
    cyc();
    set_in(0, 8'h00, 1, 8'h0F, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_hold", pt_data, 8'h51);
    end
    set_in(0, 8'h00, 1, 8'h0F, 1, 1);
    cyc();
    chk("bp_resume", pt_data, 8'h2D);
    set_in(0, 8'h00, 0, 8'h00, 0, 1);
    cyc();
    cyc();

    // overflow: five pushes, no ct traffic
    for (int i = 0; i < 5; i++) begin
      set_in(1, 8'(8'h90 + i), 0, 8'h00, 0, 1);
      cyc();
    end
    chk("ovf_stall", {7'd0, ks_stall}, 8'd1);
    chk("ovf_set", {7'd0, ks_overflow}, 8'd1);
    for (int i = 0; i < 4; i++) begin
      set_in(0, 8'h00, 1, 8'(8'h01 << i), (i == 3), 1);
      cyc();
    end
    chk("ovf_last", pt_data, 8'h9B);
    set_in(0, 8'h00, 1, 8'h55, 0, 1);
    cyc();
    cyc();
    chk("ovf_sticky", {7'd0, ks_overflow}, 8'd1);

    // reset mid-message after one of three bytes
    set_in(0, 8'h00, 0, 8'h00, 0, 1);
    cyc();
    set_in(1, 8'h5A, 1, 8'h01, 0, 1);
    cyc();
    do_reset();
    set_in(0, 8'h00, 0, 8'h00, 0, 1);
    cyc();
    chk("rst_no_done", {7'd0, msg_done}, 8'd0);

    // checksum messages: good then bad
    init_done = 1'b1;
    cyc();
    init_done = 1'b0;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 3; i++) begin
        set_in(1, 8'h00, 0, 8'h00, 0, 1);
        cyc();
      end
      set_in(0, 8'h00, 1, 8'h12, 0, 1);
      cyc();
      set_in(0, 8'h00, 1, 8'h34, 0, 1);
      cyc();
      set_in(0, 8'h00, 1, (m == 0) ? 8'h26 : 8'h27, 1, 1);
      cyc();
      set_in(0, 8'h00, 0, 8'h00, 0, 1);
      cyc();
      cyc();
    end

    // random traffic
    for (int n = 0; n < 600; n++) begin
      set_in(($urandom_range(0, 3) != 0) && !(ks_stall && $urandom_range(0, 1) == 1),
             8'($urandom), $urandom_range(0, 2) != 0, 8'($urandom),
             $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
